// File: rtl/alu_word_sequencer_if.sv
// Bundles the signals of the word sequencer. The sequencer uses the slave
// modport. The master modport is for its environment: the CPU
// microsequencer, which drives start/operands, and the shared 8-bit ALU,
// which drives alu_y/alu_cy/alu_v.
//   start/cmd/opa/opb/c_in : request from the microsequencer
//   busy/done/result/flags : status and word result back to it
//   alu_a/b/op/c/dec_*     : ALU input drive while busy
//   alu_y/alu_cy/alu_v     : ALU result returned each pass
interface alu_word_sequencer_if;
    logic        start;
    logic [2:0]  cmd;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        n_out;
    logic        z_out;
    logic        c_out;
    logic        v_out;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_c;
    logic        alu_dec_add;
    logic        alu_dec_sub;
    logic [7:0]  alu_y;
    logic        alu_cy;
    logic        alu_v;

    modport master (
        output start, cmd, opa, opb, c_in, alu_y, alu_cy, alu_v,
        input  busy, done, result, n_out, z_out, c_out, v_out,
               alu_a, alu_b, alu_op, alu_c, alu_dec_add, alu_dec_sub
    );

    modport slave (
        input  start, cmd, opa, opb, c_in, alu_y, alu_cy, alu_v,
        output busy, done, result, n_out, z_out, c_out, v_out,
               alu_a, alu_b, alu_op, alu_c, alu_dec_add, alu_dec_sub
    );
endinterface

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: performs 16-bit word operations (INW, DEW, ASW, ROW,
// ADW, LSRW, RORW) on a shared 8-bit ALU in two byte passes. The carry is
// chained between the passes, and word-wide N/Z/C/V are produced.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   ready  : global CPU ready; 0 freezes state, latches and outputs
//   bus    : slave side of alu_word_sequencer_if (request, result, ALU drive)
`ifndef kALU_ADC
`define kALU_ADC 3'd0
`endif
`ifndef kALU_SHL
`define kALU_SHL 3'd1
`endif
`ifndef kALU_SHR
`define kALU_SHR 3'd2
`endif

module alu_word_sequencer #(
    parameter logic [2:0] OP_ADC = `kALU_ADC,
    parameter logic [2:0] OP_SHL = `kALU_SHL,
    parameter logic [2:0] OP_SHR = `kALU_SHR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ready,
    alu_word_sequencer_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

    localparam logic [2:0] CMD_INW  = 3'd0;
    localparam logic [2:0] CMD_DEW  = 3'd1;
    localparam logic [2:0] CMD_ASW  = 3'd2;
    localparam logic [2:0] CMD_ROW  = 3'd3;
    localparam logic [2:0] CMD_ADW  = 3'd4;
    localparam logic [2:0] CMD_LSRW = 3'd5;
    localparam logic [2:0] CMD_RORW = 3'd6;

    state_t      state_q, state_d;
    logic [15:0] opa_q, opb_q;
    logic [2:0]  cmd_q;
    logic        cin_q;
    logic [7:0]  first_q;   // result byte from the first pass
    logic        chain_q;   // carry handed from first to second pass
    logic [15:0] result_q;
    logic        n_q, z_q, c_q, v_q;

    logic        hi_first, use_hi, rsv;
    logic [7:0]  a_byte, b_byte;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_c, c_first;
    logic [15:0] word_d;

    always_comb begin
        state_d  = state_q;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_op   = 3'd0;
        alu_c    = 1'b0;
        c_first  = 1'b0;
        rsv      = (cmd_q == 3'd7);
        hi_first = (cmd_q == CMD_LSRW) || (cmd_q == CMD_RORW);
        // Right shifts start at the high byte; the second pass takes the other byte.
        use_hi   = hi_first ^ (state_q == SECOND);
        a_byte   = use_hi ? opa_q[15:8] : opa_q[7:0];
        b_byte   = use_hi ? opb_q[15:8] : opb_q[7:0];

        unique case (state_q)
            IDLE:    if (bus.start) state_d = FIRST;
            FIRST:   state_d = SECOND;
            SECOND:  state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (state_q == FIRST || state_q == SECOND) begin
            case (cmd_q)
                CMD_INW:  begin alu_a = a_byte; alu_op = OP_ADC; c_first = 1'b1;  end
                CMD_DEW:  begin alu_a = a_byte; alu_b = 8'hFF; alu_op = OP_ADC; end
                CMD_ASW:  begin alu_a = a_byte; alu_op = OP_SHL; end
                CMD_ROW:  begin alu_a = a_byte; alu_op = OP_SHL; c_first = cin_q; end
                CMD_ADW:  begin alu_a = a_byte; alu_b = b_byte; alu_op = OP_ADC; c_first = cin_q; end
                CMD_LSRW: begin alu_a = a_byte; alu_op = OP_SHR; end
                CMD_RORW: begin alu_a = a_byte; alu_op = OP_SHR; c_first = cin_q; end
                default:  alu_op = OP_ADC;   // reserved: idle the ALU, pass opa through
            endcase
            if (!rsv) alu_c = (state_q == SECOND) ? chain_q : c_first;
        end

        if (rsv)           word_d = opa_q;
        else if (hi_first) word_d = {first_q, bus.alu_y};
        else               word_d = {bus.alu_y, first_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            cmd_q    <= '0;
            cin_q    <= 1'b0;
            first_q  <= '0;
            chain_q  <= 1'b0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else if (ready) begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.start) begin
                    opa_q <= bus.opa;
                    opb_q <= bus.opb;
                    cmd_q <= bus.cmd;
                    cin_q <= bus.c_in;
                end
                FIRST: begin
                    first_q <= bus.alu_y;
                    chain_q <= bus.alu_cy;
                end
                SECOND: begin
                    // Result is published whole so it never shows a half-updated word.
                    result_q <= word_d;
                    n_q      <= word_d[15];
                    z_q      <= (word_d == 16'h0000);
                    c_q      <= rsv ? cin_q : bus.alu_cy;
                    v_q      <= (cmd_q == CMD_ADW) ? bus.alu_v : 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.n_out       = n_q;
    assign bus.z_out       = z_q;
    assign bus.c_out       = c_q;
    assign bus.v_out       = v_q;
    assign bus.alu_a       = alu_a;
    assign bus.alu_b       = alu_b;
    assign bus.alu_op      = alu_op;
    assign bus.alu_c       = alu_c;
    assign bus.alu_dec_add = 1'b0;
    assign bus.alu_dec_sub = 1'b0;
endmodule

// File: tb/tb_alu_word_sequencer.sv
module tb_alu_word_sequencer;
    localparam logic [2:0] OP_ADC = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ready = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_word_sequencer_if bus();

    alu_word_sequencer #(.OP_ADC(OP_ADC), .OP_SHL(OP_SHL), .OP_SHR(OP_SHR)) dut (
        .clk(clk), .reset(reset), .ready(ready), .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural 8-bit ALU that answers the sequencer's drive.
    logic [8:0] s9;
    always_comb begin
        s9 = 9'd0;
        bus.alu_y  = 8'h00;
        bus.alu_cy = 1'b0;
        bus.alu_v  = 1'b0;
        case (bus.alu_op)
            OP_ADC: begin
                s9 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_c};
                bus.alu_y  = s9[7:0];
                bus.alu_cy = s9[8];
                bus.alu_v  = (bus.alu_a[7] == bus.alu_b[7]) && (s9[7] != bus.alu_a[7]);
            end
            OP_SHL: {bus.alu_cy, bus.alu_y} = {bus.alu_a, bus.alu_c};
            OP_SHR: {bus.alu_y, bus.alu_cy} = {bus.alu_c, bus.alu_a};
            default: ;
        endcase
    end

    // Word-level reference: {result, n, z, c, v}
    function automatic logic [19:0] model(input logic [2:0] cm, input logic [15:0] a, b, input logic ci);
        logic [16:0] s;
        logic [15:0] r;
        logic c, v;
        s = 17'd0; r = 16'd0; c = 1'b0; v = 1'b0;
        case (cm)
            3'd0: begin s = {1'b0, a} + 17'd1; r = s[15:0]; c = s[16]; end
            3'd1: begin s = {1'b0, a} + 17'h0FFFF; r = s[15:0]; c = s[16]; end
            3'd2: {c, r} = {a, 1'b0};
            3'd3: {c, r} = {a, ci};
            3'd4: begin
                s = {1'b0, a} + {1'b0, b} + {16'd0, ci};
                r = s[15:0]; c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'd5: {r, c} = {1'b0, a};
            3'd6: {r, c} = {ci, a};
            default: begin r = a; c = ci; end
        endcase
        return {r, r[15], (r == 16'd0), c, v};
    endfunction

    // Issues one command and waits for done. lat counts cycles from the cycle
    // start is presented to the cycle done is seen; first_a is alu_a in the
    // first busy cycle; done_after is busy|done one cycle after done.
    task automatic run_op(input logic [2:0] cm, input logic [15:0] a, b, input logic ci,
                          input bit rnd, output int lat, output logic [7:0] first_a,
                          output logic [19:0] obs, output logic done_after);
        bit seen;
        seen = 0;
        first_a = 8'h00;
        bus.cmd = cm; bus.opa = a; bus.opb = b; bus.c_in = ci; bus.start = 1'b1;
        if (rnd) ready = ($urandom_range(3) != 0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) bus.start = 1'b0;
            if (bus.busy && !seen) begin seen = 1; first_a = bus.alu_a; end
            if (rnd && !bus.done) ready = ($urandom_range(3) != 0);
        end while (!bus.done && lat < 60);
        obs = {bus.result, bus.n_out, bus.z_out, bus.c_out, bus.v_out};
        bus.start = 1'b0;
        ready = 1'b1;
        @(posedge clk); #1;
        done_after = bus.done | bus.busy;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.n_out, bus.z_out, bus.c_out, bus.v_out,
             bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c, bus.alu_dec_add, bus.alu_dec_sub} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h alu_a=%h alu_b=%h alu_op=%h required all 0",
                     bus.busy, bus.done, bus.result, bus.alu_a, bus.alu_b, bus.alu_op);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Directed vectors with hand-derived expectations.
    task automatic test_directed();
        logic [2:0]  cm [9]  = '{3'd0, 3'd1, 3'd1, 3'd4, 3'd4, 3'd5, 3'd6, 3'd2, 3'd7};
        logic [15:0] av [9]  = '{16'h00FF, 16'h0000, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h4000, 16'hA5C3};
        logic [15:0] bv [9]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h1234};
        logic        cv [9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [19:0] ex [9]  = '{{16'h0100, 4'b0000}, {16'hFFFF, 4'b1000}, {16'h0000, 4'b0110},
                                 {16'h8000, 4'b1001}, {16'h0000, 4'b0110}, {16'h0000, 4'b0110},
                                 {16'h8000, 4'b1000}, {16'h8000, 4'b1000}, {16'hA5C3, 4'b1010}};
        logic [7:0]  fa [9]  = '{8'hFF, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        int lat; logic [7:0] first_a; logic [19:0] obs; logic da;
        for (int i = 0; i < 9; i++) begin
            run_op(cm[i], av[i], bv[i], cv[i], 0, lat, first_a, obs, da);
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL directed_%0d_result: got res=%h nzcv=%b required res=%h nzcv=%b",
                         i, obs[19:4], obs[3:0], ex[i][19:4], ex[i][3:0]);
            end
            checks++;
            if (lat !== 3) begin failures++; $display("FAIL directed_%0d_latency: got %0d required 3", i, lat); end
            checks++;
            if (first_a !== fa[i]) begin failures++; $display("FAIL directed_%0d_first_a: got %h required %h", i, first_a, fa[i]); end
            checks++;
            if (da !== 1'b0) begin failures++; $display("FAIL directed_%0d_done_pulse: busy|done after done = %b required 0", i, da); end
        end
    endtask

    // ROW 8000 with ready low for two cycles in the second pass.
    task automatic test_stall();
        int lat;
        bus.cmd = 3'd3; bus.opa = 16'h8000; bus.opb = 16'h0; bus.c_in = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0; lat = 1;
        @(posedge clk); #1; lat++;
        ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1; lat++;
            checks++;
            if ({bus.busy, bus.done, bus.alu_a, bus.alu_op, bus.alu_c} !== {1'b1, 1'b0, 8'h80, OP_SHL, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold_%0d: busy=%b done=%b alu_a=%h op=%h c=%b required 1 0 80 %h 0",
                         k, bus.busy, bus.done, bus.alu_a, bus.alu_op, bus.alu_c, OP_SHL);
            end
        end
        ready = 1'b1;
        while (!bus.done && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL stall_latency: got %0d required 5", lat); end
        checks++;
        if ({bus.result, bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== {16'h0001, 4'b0010}) begin
            failures++;
            $display("FAIL stall_result: got res=%h c=%b required res=0001 c=1", bus.result, bus.c_out);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c} !== '0) begin
            failures++;
            $display("FAIL stall_done_drive: alu_a=%h alu_b=%h op=%h c=%b required 0", bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL stall_done_pulse: done=%b required 0", bus.done); end
    endtask

    task automatic test_start_not_ready();
        ready = 1'b0; bus.start = 1'b1; bus.cmd = 3'd0; bus.opa = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.busy !== 1'b0) begin failures++; $display("FAIL start_not_ready_%0d: busy=%b required 0", k, bus.busy); end
        end
        bus.start = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL start_dropped: busy=%b required 0", bus.busy); end
    endtask

    task automatic test_mid_reset();
        int lat; logic [7:0] first_a; logic [19:0] obs; logic da;
        bit pulsed;
        bus.cmd = 3'd2; bus.opa = 16'h1357; bus.c_in = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_reset_busy: busy=%b required 1", bus.busy); end
        reset = 1'b1; #2;
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.n_out, bus.z_out, bus.c_out, bus.v_out,
             bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b result=%h alu_a=%h op=%h required 0",
                     bus.busy, bus.done, bus.result, bus.alu_a, bus.alu_op);
        end
        @(posedge clk); #1; reset = 1'b0;
        pulsed = 0;
        for (int k = 0; k < 5; k++) begin @(posedge clk); #1; if (bus.done || bus.busy) pulsed = 1; end
        checks++;
        if (pulsed) begin failures++; $display("FAIL mid_reset_no_done: activity seen after reset required none"); end
        run_op(3'd2, 16'h4000, 16'h0, 1'b0, 0, lat, first_a, obs, da);
        checks++;
        if (obs !== {16'h8000, 4'b1000}) begin
            failures++;
            $display("FAIL post_reset_asw: got res=%h nzcv=%b required res=8000 nzcv=1000", obs[19:4], obs[3:0]);
        end
    endtask

    task automatic test_random(input bit rnd_ready, input int n);
        int lat; logic [7:0] first_a; logic [19:0] obs, exp_o; logic da;
        logic [2:0] cm; logic [15:0] a, b; logic ci; logic [7:0] exp_fa;
        for (int i = 0; i < n; i++) begin
            cm = 3'($urandom_range(7)); a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
            if (i % 8 == 0) a = (i % 16 == 0) ? 16'hFFFF : 16'h0000;
            run_op(cm, a, b, ci, rnd_ready, lat, first_a, obs, da);
            exp_o  = model(cm, a, b, ci);
            exp_fa = (cm == 3'd7) ? 8'h00 : (cm == 3'd5 || cm == 3'd6) ? a[15:8] : a[7:0];
            checks++;
            if (obs !== exp_o || lat >= 60) begin
                failures++;
                $display("FAIL random_%0d cmd=%0d a=%h b=%h ci=%b: got res=%h nzcv=%b lat=%0d required res=%h nzcv=%b",
                         i, cm, a, b, ci, obs[19:4], obs[3:0], lat, exp_o[19:4], exp_o[3:0]);
            end
            if (!rnd_ready) begin
                checks++;
                if (lat !== 3 || first_a !== exp_fa) begin
                    failures++;
                    $display("FAIL random_%0d_timing: lat=%0d first_a=%h required lat=3 first_a=%h", i, lat, first_a, exp_fa);
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.cmd = 3'd0; bus.opa = 16'h0; bus.opb = 16'h0; bus.c_in = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_start_not_ready();
        test_mid_reset();
        test_random(0, 40);
        test_random(1, 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
